fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter, drives the fetch address to the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. Next-PC selection (sequential, branch, jump, register jump) is resolved here using the instruction held in IF/ID, with one architectural delay slot. Stall requests from the hazard unit are honoured.

---
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
//
// Purpose:
//   Instruction-fetch stage of the five-stage MIPS pipeline. It holds the
//   program counter and presents it to the combinational instruction memory.
//   The returned word is captured into the IF/ID pipeline register.
//   Next-PC selection is resolved from the instruction already held in IF/ID.
//   That instruction is the branch or jump currently in ID. The word fetched
//   in the same cycle is its delay slot and is always kept.
//
// Ports:
//   clk      in   1  rising-edge clock
//   reset    in   1  asynchronous, active-low reset
//   stall    in   1  hold PC and IF/ID this cycle
//   instr_f  in  32  instruction memory word for pc_f
//   npc_sel  in   2  00 pc+4, 01 branch, 10 j/jal, 11 jr/jalr
//   br_take  in   1  branch comparator result (used with npc_sel=01)
//   jr_addr  in  32  forwarded rs value for register jumps
//   pc_f     out 32  current fetch address
//   instr_d  out 32  IF/ID instruction
//   pc_d     out 32  IF/ID pc of instr_d
//   pc8_d    out 32  pc_d + 8, link address for jal/jalr
//   valid_d  out  1  IF/ID holds a fetched instruction
//   adel_d   out  1  fetch address error flagged for instr_d
//
// Configuration:
//   FETCH_ADDR_CHECK_EN
//     When this macro is defined, a fetch from a misaligned address is
//     treated as an address error. So is a fetch from an address outside
//     [PC_RESET, PC_LIMIT]. Either case captures a nop and raises adel_d.
//     When the macro is not defined, adel_d is constantly 0.

module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr_f,
  input  logic [1:0]  npc_sel,
  input  logic        br_take,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        adel_d
);

  logic [1:0]  sel_eff;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] pc_next;
  logic [31:0] instr_cap;
  logic        addr_bad;

  // An empty IF/ID slot (just after reset) must not redirect the PC.
  assign sel_eff   = valid_d ? npc_sel : 2'b00;
  assign pc_plus4  = pc_f + 32'd4;
  assign br_target = pc_d + 32'd4 + {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
  assign j_target  = {pc_d[31:28], instr_d[25:0], 2'b00};

  // Next-PC mux; a not-taken branch falls through to sequential fetch.
  always_comb begin
    pc_next = pc_plus4;
    case (sel_eff)
      2'b01:   if (br_take) pc_next = br_target;
      2'b10:   pc_next = j_target;
      2'b11:   pc_next = jr_addr;
      default: pc_next = pc_plus4;
    endcase
  end

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [31:0] PC_LIMIT = 32'h0000_6FFC;

  // A bad fetch address turns the captured word into a nop.
  // PC flow is unaffected; the exception unit acts on adel_d.
  assign addr_bad  = (pc_f[1:0] != 2'b00) || (pc_f < PC_RESET) || (pc_f > PC_LIMIT);
  assign instr_cap = addr_bad ? 32'h0000_0000 : instr_f;
`else
  assign addr_bad  = 1'b0;
  assign instr_cap = instr_f;
`endif

  // PC and IF/ID register. Reset overrides everything asynchronously.
  // A stall freezes the whole stage, including any pending redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f    <= PC_RESET;
      instr_d <= 32'h0000_0000;
      pc_d    <= 32'h0000_0000;
      pc8_d   <= 32'h0000_0000;
      valid_d <= 1'b0;
      adel_d  <= 1'b0;
    end else if (!stall) begin
      pc_f    <= pc_next;
      instr_d <= instr_cap;
      pc_d    <= pc_f;
      pc8_d   <= pc_f + 32'd8;
      valid_d <= 1'b1;
      adel_d  <= addr_bad;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//
// Purpose:
//   Self-checking bench for fetch_stage. It runs directed scenarios first,
//   then randomized stall and next-PC selection. Every output is compared
//   against a behavioural model of the PC and the IF/ID slot.
//
// The instruction memory is a hash of the address. A few addresses are
// patched with real branch/jump encodings for the directed cases.

module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] LIM_PC = 32'h0000_6FFC;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] instr_f;
  logic [1:0]  npc_sel;
  logic        br_take;
  logic [31:0] jr_addr;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        valid_d;
  logic        adel_d;

  int checks = 0;
  int errors = 0;

  logic [31:0] patch [logic [31:0]];

  // model state: the PC and the contents of the IF/ID slot
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  logic        m_valid;
  logic        m_adel;

  fetch_stage dut (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .instr_f (instr_f),
    .npc_sel (npc_sel),
    .br_take (br_take),
    .jr_addr (jr_addr),
    .pc_f    (pc_f),
    .instr_d (instr_d),
    .pc_d    (pc_d),
    .pc8_d   (pc8_d),
    .valid_d (valid_d),
    .adel_d  (adel_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (patch.exists(addr)) return patch[addr];
    return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign instr_f = memWord(pc_f);

  function automatic logic addrBad(input logic [31:0] addr);
`ifdef FETCH_ADDR_CHECK_EN
    return (addr % 4 != 0) || (addr < RST_PC) || (addr > LIM_PC);
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".pc_f"},    pc_f,    m_pc);
    checkOutput({tag, ".instr_d"}, instr_d, m_instr);
    checkOutput({tag, ".pc_d"},    pc_d,    m_pcd);
    checkOutput({tag, ".pc8_d"},   pc8_d,   m_valid ? m_pcd + 32'd8 : 32'd0);
    checkOutput({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, m_valid});
    checkOutput({tag, ".adel_d"},  {31'd0, adel_d},  {31'd0, m_adel});
  endtask

  function automatic void modelReset();
    m_pc    = RST_PC;
    m_instr = 32'd0;
    m_pcd   = 32'd0;
    m_valid = 1'b0;
    m_adel  = 1'b0;
  endfunction

  // advance the model by one clock edge with the given ID-side inputs
  function automatic void modelEdge(input logic st, input logic [1:0] sel,
                                    input logic take, input logic [31:0] jra);
    logic [31:0] target;
    int          offs;
    if (st) return;
    target = m_pc + 32'd4;
    if (m_valid) begin
      if (sel == 2'd1 && take) begin
        offs   = $signed(m_instr[15:0]);
        target = m_pcd + 32'd4 + 32'(offs * 4);
      end else if (sel == 2'd2) begin
        target = (m_pcd & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
      end else if (sel == 2'd3) begin
        target = jra;
      end
    end
    m_adel  = addrBad(m_pc);
    m_instr = m_adel ? 32'd0 : memWord(m_pc);
    m_pcd   = m_pc;
    m_valid = 1'b1;
    m_pc    = target;
  endfunction

  // drive one cycle of inputs, let an edge pass, then check at the falling edge
  task automatic applyStimulus(input logic st, input logic [1:0] sel,
                               input logic take, input logic [31:0] jra, input string tag);
    stall   = st;
    npc_sel = sel;
    br_take = take;
    jr_addr = jra;
    modelEdge(st, sel, take, jra);
    @(posedge clk);
    @(negedge clk);
    compareAll(tag);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset   = 1'b0;
    stall   = 1'b0;
    npc_sel = 2'd0;
    br_take = 1'b0;
    modelReset();
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst.pc_f", pc_f, RST_PC);
    end
    compareAll("rst");
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    stall   = 1'b0;
    npc_sel = 2'd0;
    br_take = 1'b0;
    jr_addr = 32'd0;
    patch[32'h0000_3000] = 32'h0800_0C40;  // j, target field 0xC40
    patch[32'h0000_3008] = 32'h1000_FFFE;  // beq, offset -2 words
    modelReset();

    // reset, first fetch and a straight-line run
    doReset();
    applyStimulus(1'b0, 2'd0, 1'b0, 32'd0, "first");
    checkOutput("first.instr_d", instr_d, 32'h0800_0C40);
    checkOutput("first.pc8_d", pc8_d, 32'h0000_3008);
    checkOutput("first.pc_f", pc_f, 32'h0000_3004);
    repeat (4) applyStimulus(1'b0, 2'd0, 1'b0, 32'd0, "seq");
    checkOutput("seq5.pc_f", pc_f, 32'h0000_3014);
    checkOutput("seq5.pc_d", pc_d, 32'h0000_3010);

    // jump from 0x3000; jal link value is 0x3008
    doReset();
    applyStimulus(1'b0, 2'd0, 1'b0, 32'd0, "j.fetch");
    applyStimulus(1'b0, 2'd2, 1'b0, 32'd0, "j.redir");
    checkOutput("j.pc_f", pc_f, 32'h0000_3100);
    checkOutput("j.slot_pc_d", pc_d, 32'h0000_3004);

    // taken beq at 0x3008: the delay slot at 0x300C still enters IF/ID
    doReset();
    repeat (3) applyStimulus(1'b0, 2'd0, 1'b0, 32'd0, "beq.pre");
    applyStimulus(1'b0, 2'd1, 1'b1, 32'd0, "beq.take");
    checkOutput("beq.pc_f", pc_f, 32'h0000_3004);
    checkOutput("beq.slot_pc_d", pc_d, 32'h0000_300C);

    // not-taken beq falls through
    doReset();
    repeat (3) applyStimulus(1'b0, 2'd0, 1'b0, 32'd0, "bnt.pre");
    applyStimulus(1'b0, 2'd1, 1'b0, 32'd0, "bnt");
    checkOutput("bnt.pc_f", pc_f, 32'h0000_3010);

    // jr held by two stall cycles; the redirect applies after release
    doReset();
    applyStimulus(1'b0, 2'd0, 1'b0, 32'd0, "jr.pre");
    applyStimulus(1'b1, 2'd3, 1'b0, 32'h0000_3020, "jr.st1");
    applyStimulus(1'b1, 2'd3, 1'b0, 32'h0000_3020, "jr.st2");
    checkOutput("jr.frozen_pc_f", pc_f, 32'h0000_3004);
    applyStimulus(1'b0, 2'd3, 1'b0, 32'h0000_3020, "jr.rel");
    checkOutput("jr.pc_f", pc_f, 32'h0000_3020);

    // misaligned register jump target
    applyStimulus(1'b0, 2'd3, 1'b0, 32'h0000_3022, "jrbad.redir");
    applyStimulus(1'b0, 2'd0, 1'b0, 32'd0, "jrbad.cap");
    checkOutput("jrbad.pc_d", pc_d, 32'h0000_3022);
`ifdef FETCH_ADDR_CHECK_EN
    checkOutput("jrbad.adel", {31'd0, adel_d}, 32'd1);
    checkOutput("jrbad.instr_d", instr_d, 32'd0);
`else
    checkOutput("jrbad.adel", {31'd0, adel_d}, 32'd0);
    checkOutput("jrbad.instr_d", instr_d, memWord(32'h0000_3022));
`endif

    // asynchronous reset in the middle of a stalled cycle
    stall = 1'b1;
    #2 reset = 1'b0;
    #1;
    modelReset();
    compareAll("areset");
    doReset();

    // randomized run
    for (int i = 0; i < 400; i++) begin
      logic        st;
      logic [1:0]  sel;
      logic        take;
      logic [31:0] jra;
      st   = ($urandom_range(0, 3) == 0);
      sel  = 2'($urandom_range(0, 3));
      take = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) jra = $urandom;
      else jra = RST_PC + 32'($urandom_range(0, 32'hFFF)) * 4;
      if ($urandom_range(0, 99) == 0) doReset();
      applyStimulus(st, sel, take, jra, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
